hdmi_scanout_ctrl: RTL and testbench



---
 rtl/hdmi_pkg.sv | 35 +++
 rtl/hdmi_raster_cnt.sv | 67 ++++++
 rtl/hdmi_scanout_ctrl.sv | 135 +++++++++++++
 tb/tb_hdmi_scanout_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared definitions for the HDMI scan-out controller.
//   - scan_state_e : scan-out FSM states
//   - DEF_*        : default 640x480@60 timing (25 MHz pixel clock)
//   - line_total() : total length of a line/frame from its four segments
//   - in_window()  : half-open window test used for sync generation
package hdmi_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_STREAM,
        ST_UNDERRUN
    } scan_state_e;

    function automatic int line_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // True when lo <= pos < lo+width.
    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int width);
        return (int'(pos) >= lo) && (int'(pos) < lo + width);
    endfunction

endpackage

// File: rtl/hdmi_raster_cnt.sv
// hdmi_raster_cnt: free-running raster position counters.
//   clk_i, rst_ni  : pixel clock, async active-low reset
//   cx_o, cy_o     : current column / line
//   active_o       : position is inside the visible area
//   hs_win_o       : position is inside the hsync window (column based)
//   vs_win_o       : position is inside the vsync window (line based)
//   frame_end_o    : last pixel of the last line
module hdmi_raster_cnt
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] cx_o,
    output logic [CNT_W-1:0] cy_o,
    output logic             active_o,
    output logic             hs_win_o,
    output logic             vs_win_o,
    output logic             frame_end_o
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;
    logic             line_end;

    assign line_end    = (cx_q == H_LAST);
    assign frame_end_o = line_end && (cy_q == V_LAST);

    always_comb begin
        cx_d = cx_q + 1'b1;
        cy_d = cy_q;
        if (line_end) begin
            cx_d = '0;
            cy_d = frame_end_o ? '0 : cy_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o     = cx_q;
    assign cy_o     = cy_q;
    assign active_o = (cx_q < CNT_W'(H_ACTIVE)) && (cy_q < CNT_W'(V_ACTIVE));
    assign hs_win_o = in_window(cx_q, H_ACTIVE + H_FP, H_SYNC);
    assign vs_win_o = in_window(cy_q, V_ACTIVE + V_FP, V_SYNC);

endmodule

// File: rtl/hdmi_scanout_ctrl.sv
// hdmi_scanout_ctrl: video timing + pixel fetch for the TMDS encoders.
//   pixclk, reset        : pixel clock, async active-low reset
//   pi_enable            : scan-out request, acted on at frame boundaries
//   pi_pix_valid/data    : upstream 24-bit {R,G,B} stream
//   po_pix_ready         : upstream pixel consumed when high with valid
//   po_red/green/blue    : registered pixel
//   po_de/hsync/vsync    : registered timing, aligned with the pixel
//   po_frame_start       : pulse with pixel (0,0) of a streamed frame
//   po_underrun          : high while the current frame is starved
//   po_underrun_cnt      : saturating count of underrun events
module hdmi_scanout_ctrl
    import hdmi_pkg::*;
#(
    parameter int          H_ACTIVE     = DEF_H_ACTIVE,
    parameter int          H_FP         = DEF_H_FP,
    parameter int          H_SYNC       = DEF_H_SYNC,
    parameter int          H_BP         = DEF_H_BP,
    parameter int          V_ACTIVE     = DEF_V_ACTIVE,
    parameter int          V_FP         = DEF_V_FP,
    parameter int          V_SYNC       = DEF_V_SYNC,
    parameter int          V_BP         = DEF_V_BP,
    parameter logic        SYNC_ACT     = 1'b1,
    parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        pi_enable,
    input  logic        pi_pix_valid,
    input  logic [23:0] pi_pix_data,
    output logic        po_pix_ready,
    output logic [7:0]  po_red,
    output logic [7:0]  po_green,
    output logic [7:0]  po_blue,
    output logic        po_de,
    output logic        po_hsync,
    output logic        po_vsync,
    output logic        po_frame_start,
    output logic        po_underrun,
    output logic [15:0] po_underrun_cnt
);

    logic [CNT_W-1:0] cx, cy;
    logic             active, hs_win, vs_win, frame_end;

    hdmi_raster_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_raster (
        .clk_i       (pixclk),
        .rst_ni      (reset),
        .cx_o        (cx),
        .cy_o        (cy),
        .active_o    (active),
        .hs_win_o    (hs_win),
        .vs_win_o    (vs_win),
        .frame_end_o (frame_end)
    );

    scan_state_e state_q, state_d;
    logic [23:0] rgb_q, rgb_d;
    logic        de_q, hs_q, vs_q, fs_q, fs_d;
    logic [15:0] ucnt_q, ucnt_d;
    logic        starve;

    // Ready depends only on registered state and position so upstream never
    // sees a combinational path from its own valid.
    assign po_pix_ready = (state_q == ST_STREAM) && active;
    assign starve       = po_pix_ready && !pi_pix_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (pi_enable) state_d = ST_ARMED;
            ST_ARMED:    if (frame_end) state_d = pi_enable ? ST_STREAM : ST_IDLE;
            // Starvation only happens in the active area, frame_end never
            // does, so the two branches cannot collide.
            ST_STREAM: begin
                if (starve)                       state_d = ST_UNDERRUN;
                else if (frame_end && !pi_enable) state_d = ST_IDLE;
            end
            ST_UNDERRUN: if (frame_end) state_d = pi_enable ? ST_STREAM : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rgb_d = '0;
        if (active) begin
            case (state_q)
                ST_STREAM:   rgb_d = pi_pix_valid ? pi_pix_data : UNDERRUN_RGB;
                ST_UNDERRUN: rgb_d = UNDERRUN_RGB;
                default:     rgb_d = '0;
            endcase
        end
    end

    assign fs_d = (state_q == ST_STREAM) && (cx == '0) && (cy == '0);

    always_comb begin
        ucnt_d = ucnt_q;
        if ((state_q == ST_STREAM) && starve && (ucnt_q != 16'hFFFF))
            ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_ACT;
            vs_q    <= ~SYNC_ACT;
            fs_q    <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rgb_q   <= rgb_d;
            de_q    <= active;
            hs_q    <= hs_win ? SYNC_ACT : ~SYNC_ACT;
            vs_q    <= vs_win ? SYNC_ACT : ~SYNC_ACT;
            fs_q    <= fs_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign po_red          = rgb_q[23:16];
    assign po_green        = rgb_q[15:8];
    assign po_blue         = rgb_q[7:0];
    assign po_de           = de_q;
    assign po_hsync        = hs_q;
    assign po_vsync        = vs_q;
    assign po_frame_start  = fs_q;
    assign po_underrun     = (state_q == ST_UNDERRUN);
    assign po_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_hdmi_scanout_ctrl.sv
// Bench for hdmi_scanout_ctrl using a reduced raster (16x11, 8x6 visible)
// so whole frames fit in a short run. A frame-level reference model predicts
// every cycle; a phase table adds frame-level totals.
module tb_hdmi_scanout_ctrl;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam logic [23:0] MAG = 24'hFF00FF;

    logic        pixclk = 1'b0;
    logic        reset = 1'b0;
    logic        pi_enable = 1'b0;
    logic        pi_pix_valid = 1'b0;
    logic [23:0] pi_pix_data = '0;
    logic        po_pix_ready;
    logic [7:0]  po_red, po_green, po_blue;
    logic        po_de, po_hsync, po_vsync, po_frame_start, po_underrun;
    logic [15:0] po_underrun_cnt;

    always #20 pixclk = ~pixclk;

    hdmi_scanout_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_ACT (1'b1), .UNDERRUN_RGB (MAG)
    ) dut (
        .pixclk          (pixclk),
        .reset           (reset),
        .pi_enable       (pi_enable),
        .pi_pix_valid    (pi_pix_valid),
        .pi_pix_data     (pi_pix_data),
        .po_pix_ready    (po_pix_ready),
        .po_red          (po_red),
        .po_green        (po_green),
        .po_blue         (po_blue),
        .po_de           (po_de),
        .po_hsync        (po_hsync),
        .po_vsync        (po_vsync),
        .po_frame_start  (po_frame_start),
        .po_underrun     (po_underrun),
        .po_underrun_cnt (po_underrun_cnt)
    );

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: raster position, whether this frame is streamed,
    // whether it has starved, and whether a scan-out request is pending.
    int          mx, my, cnt;
    bit          streaming, starved, armed;
    logic [23:0] seq;
    int          ph_ready, ph_fs;

    task automatic model_reset();
        mx = 0; my = 0; cnt = 0;
        streaming = 0; starved = 0; armed = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, po_pix_ready, 0);
        chk({tag, "_rgb"}, {po_red, po_green, po_blue}, 0);
        chk({tag, "_de"}, po_de, 0);
        chk({tag, "_sync"}, {po_hsync, po_vsync}, 2'b00);
        chk({tag, "_fs"}, po_frame_start, 0);
        chk({tag, "_ur"}, po_underrun, 0);
        chk({tag, "_cnt"}, po_underrun_cnt, 0);
    endtask

    // vmode: 0 valid held high, 1 valid dropped only at (5,3), 2 random
    task automatic step(input bit en, input int vmode);
        bit          v, act, rdy_e, hs_e, vs_e, fs_e, nxt, rdy_seen;
        logic [23:0] d, rgb_e;
        @(negedge pixclk);
        case (vmode)
            0:       v = 1'b1;
            1:       v = !(mx == 5 && my == 3);
            default: v = ($urandom_range(0, 7) != 0);
        endcase
        d = (vmode == 2) ? 24'($urandom) : seq;
        pi_enable = en; pi_pix_valid = v; pi_pix_data = d;
        #1;
        act   = (mx < HA) && (my < VA);
        rdy_e = streaming && act && !starved;
        chk("ready", po_pix_ready, rdy_e);
        chk("underrun", po_underrun, streaming && starved);
        chk("ucnt", po_underrun_cnt, cnt);
        rdy_seen = po_pix_ready;
        rgb_e = '0;
        if (act && streaming) rgb_e = (starved || !v) ? MAG : d;
        hs_e = (mx >= HA + HFP) && (mx < HA + HFP + HS);
        vs_e = (my >= VA + VFP) && (my < VA + VFP + VS);
        fs_e = streaming && mx == 0 && my == 0;
        if (rdy_e && v) seq = seq + 24'h010203;
        if (rdy_e && !v) begin
            starved = 1;
            if (cnt < 65535) cnt++;
        end
        if (mx == HT - 1 && my == VT - 1) begin
            nxt = en && (streaming || armed);
            armed = en && !streaming && !armed;
            streaming = nxt;
            starved = 0;
        end else if (!streaming && en) begin
            armed = 1;
        end
        mx++;
        if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end
        @(posedge pixclk);
        #1;
        chk("rgb", {po_red, po_green, po_blue}, rgb_e);
        chk("de", po_de, act);
        chk("hsync", po_hsync, hs_e);
        chk("vsync", po_vsync, vs_e);
        chk("fstart", po_frame_start, fs_e);
        ph_ready += int'(rdy_seen);
        ph_fs    += int'(po_frame_start);
    endtask

    typedef struct {
        bit    en;
        int    vmode;
        int    ncyc;
        int    exp_ready;   // -1: not checked
        int    exp_fs;
        int    exp_cnt;     // -1: not checked
        string nm;
    } phase_t;

    phase_t tbl[9];

    initial begin
        tbl[0] = '{0, 0, 2*HT*VT,   0,  0,  0, "idle2f"};
        tbl[1] = '{0, 0, 100,       0,  0,  0, "idle_pre"};
        tbl[2] = '{1, 0, 76+HT*VT,  HA*VA, 1, 0, "arm_stream"};
        tbl[3] = '{1, 1, HT*VT,     30, 1,  1, "drop"};
        tbl[4] = '{1, 2, 2*HT*VT,   -1, 2, -1, "random"};
        tbl[5] = '{1, 0, HT*VT,     HA*VA, 1, -1, "recover"};
        tbl[6] = '{1, 0, 3*HT,      3*HA, 1, -1, "endrop_a"};
        tbl[7] = '{0, 0, (VT-3)*HT, 3*HA, 0, -1, "endrop_b"};
        tbl[8] = '{0, 0, HT*VT,     0,  0, -1, "off_after"};

        seq = 24'h000001;
        model_reset();
        repeat (3) @(posedge pixclk);
        #1 chk_reset_vals("rst_init");
        #4 reset = 1'b1;

        for (int p = 0; p < 9; p++) begin
            ph_ready = 0; ph_fs = 0;
            for (int c = 0; c < tbl[p].ncyc; c++) step(tbl[p].en, tbl[p].vmode);
            if (tbl[p].exp_ready >= 0) chk({tbl[p].nm, "_nready"}, ph_ready, tbl[p].exp_ready);
            chk({tbl[p].nm, "_nfs"}, ph_fs, tbl[p].exp_fs);
            if (tbl[p].exp_cnt >= 0) chk({tbl[p].nm, "_cnt"}, po_underrun_cnt, tbl[p].exp_cnt);
        end

        // Reset in the middle of a line of a streamed frame.
        for (int c = 0; c < 2*HT*VT + 3*HT + 4; c++) step(1'b1, 0);
        @(negedge pixclk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_mid");
        model_reset();
        repeat (2) @(posedge pixclk);
        #1 chk_reset_vals("rst_hold");
        #4 reset = 1'b1;

        // First frame after release may arm but must not stream.
        ph_ready = 0; ph_fs = 0;
        for (int c = 0; c < HT*VT; c++) step(1'b1, 0);
        chk("post_rst_f0_nready", ph_ready, 0);
        ph_ready = 0; ph_fs = 0;
        for (int c = 0; c < HT*VT; c++) step(1'b1, 0);
        chk("post_rst_f1_nready", ph_ready, HA*VA);
        chk("post_rst_f1_nfs", ph_fs, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
